button_debouncer: RTL

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 119 +++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Five-channel pushbutton debouncer: 2-flop sync, per-channel FSM and
// stability counter, level plus one-clock press/release pulses.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] db_level,
  output logic [4:0] press_pulse,
  output logic [4:0] release_pulse,
  output logic       any_level
);

  localparam int unsigned CW = 21;

  localparam logic [4:0] S_IDLE     = 5'b00001;
  localparam logic [4:0] S_WAIT_PRS = 5'b00010;
  localparam logic [4:0] S_PULSE    = 5'b00100;
  localparam logic [4:0] S_HELD     = 5'b01000;
  localparam logic [4:0] S_WAIT_REL = 5'b10000;

  localparam logic [CW-1:0] LP_LAST = CW'(STABLE_CYCLES - 1);

  logic [4:0] r_sync1;
  logic [4:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 5; g++) begin : g_ch
    logic [4:0]    r_state;
    logic [4:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_rel;
    logic          w_rel_nxt;
    logic          w_in;
    logic          w_last;

    assign w_in   = r_sync2[g];
    assign w_last = (r_cnt == LP_LAST);

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rel_nxt   = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_in) begin
            w_state_nxt = S_WAIT_PRS;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_PRS: begin
          if (!w_in) begin
            w_state_nxt = S_IDLE;
          end else if (w_last) begin
            w_state_nxt = S_PULSE;
          end else begin
            w_cnt_nxt = r_cnt + 21'd1;
          end
        end
        S_PULSE: begin
          w_state_nxt = S_HELD;
        end
        S_HELD: begin
          if (!w_in) begin
            w_state_nxt = S_WAIT_REL;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_REL: begin
          if (w_in) begin
            w_state_nxt = S_HELD;
          end else if (w_last) begin
            w_state_nxt = S_IDLE;
            w_rel_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 21'd1;
          end
        end
        // Corrupted one-hot encodings fall back to a clean idle.
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_rel   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_rel   <= w_rel_nxt;
      end
    end

    assign press_pulse[g]   = (r_state == S_PULSE);
    assign db_level[g]      = (r_state == S_PULSE)
                            | (r_state == S_HELD)
                            | (r_state == S_WAIT_REL);
    assign release_pulse[g] = r_rel;
  end

  assign any_level = |db_level;

endmodule
